// File: rtl/sampler_voice_scheduler.sv
`default_nettype none
// sampler_voice_scheduler: four-voice sample playback sharing one registered-output RAM.
// Rev 1.0 - initial release.
module sampler_voice_scheduler #(
  parameter int W         = 16,
  parameter int FP_OFFSET = 2,
  parameter int SLOT_LEN  = 1680,
  parameter int ADDR_W    = 13,
  parameter int RATE_DIV  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_strobe,
  input  logic signed [W-1:0]      sample_in0,
  input  logic signed [W-1:0]      sample_in1,
  input  logic signed [W-1:0]      sample_in2,
  input  logic signed [W-1:0]      sample_in3,
  output logic signed [W-1:0]      sample_out0,
  output logic signed [W-1:0]      sample_out1,
  output logic signed [W-1:0]      sample_out2,
  output logic signed [W-1:0]      sample_out3,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic signed [W-1:0]      rd_data,
  output logic                     busy,
  output logic [3:0]               voice_active,
  output logic                     overrun
);

  localparam int PW = $clog2(SLOT_LEN + 1);
  localparam int RW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [PW-1:0]       POS_END  = PW'(SLOT_LEN);
  localparam logic [RW-1:0]       RDIV_MAX = RW'(RATE_DIV - 1);
  localparam logic signed [W-1:0] TRIG_LO  = W'(500 << FP_OFFSET);
  localparam logic signed [W-1:0] TRIG_HI  = W'(1000 << FP_OFFSET);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, COMMIT} state_t;

  state_t              state, state_nxt;
  logic [1:0]          v;
  logic [PW-1:0]       pos [4];
  logic signed [W-1:0] shadow [4];
  logic signed [W-1:0] trig_in [4];
  logic [3:0]          armed, fresh, active;
  logic [RW-1:0]       rdiv;
  logic                adv;
  logic [ADDR_W-1:0]   addr_q;

  always_comb begin
    trig_in[0] = sample_in0;
    trig_in[1] = sample_in1;
    trig_in[2] = sample_in2;
    trig_in[3] = sample_in3;
    for (int i = 0; i < 4; i++) active[i] = (pos[i] < POS_END);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // rd_addr is only driven fresh in an active ISSUE cycle; otherwise it replays the last address.
  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    rd_addr   = addr_q;
    case (state)
      IDLE:    if (sample_strobe) state_nxt = ISSUE;
      ISSUE: begin
        if (active[v]) begin
          rd_en   = 1'b1;
          rd_addr = ADDR_W'(v) * ADDR_W'(SLOT_LEN) + ADDR_W'(pos[v]);
        end
        state_nxt = CAPTURE;
      end
      CAPTURE: state_nxt = (v == 2'd3) ? COMMIT : ISSUE;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v            <= 2'd0;
      armed        <= 4'd0;
      fresh        <= 4'd0;
      rdiv         <= '0;
      adv          <= 1'b0;
      addr_q       <= '0;
      overrun      <= 1'b0;
      voice_active <= 4'd0;
      sample_out0  <= '0;
      sample_out1  <= '0;
      sample_out2  <= '0;
      sample_out3  <= '0;
      for (int i = 0; i < 4; i++) begin
        pos[i]    <= POS_END;
        shadow[i] <= '0;
      end
    end else begin
      voice_active <= active;
      if (sample_strobe && state != IDLE) overrun <= 1'b1;
      if (rd_en) addr_q <= rd_addr;
      case (state)
        IDLE: begin
          if (sample_strobe) begin
            v    <= 2'd0;
            adv  <= (rdiv == '0);
            rdiv <= (rdiv == RDIV_MAX) ? '0 : rdiv + 1'b1;
            // Firing beats arming; between thresholds the armed bit holds.
            for (int i = 0; i < 4; i++) begin
              if (armed[i] && trig_in[i] >= TRIG_HI) begin
                pos[i]   <= '0;
                fresh[i] <= 1'b1;
                armed[i] <= 1'b0;
              end else if (trig_in[i] < TRIG_LO) begin
                armed[i] <= 1'b1;
              end
            end
          end
        end
        CAPTURE: begin
          shadow[v] <= active[v] ? rd_data : '0;
          if (active[v] && adv && !fresh[v]) pos[v] <= pos[v] + 1'b1;
          if (v != 2'd3) v <= v + 2'd1;
        end
        COMMIT: begin
          sample_out0 <= shadow[0];
          sample_out1 <= shadow[1];
          sample_out2 <= shadow[2];
          sample_out3 <= shadow[3];
          fresh       <= 4'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sampler_voice_scheduler.sv
`default_nettype none
// tb_sampler_voice_scheduler: directed checks of triggering, playback, timing and reset.
// Rev 1.0 - initial release.
module tb_sampler_voice_scheduler;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               sample_strobe = 1'b0;
  logic signed [15:0] sample_in0 = '0, sample_in1 = '0, sample_in2 = '0, sample_in3 = '0;
  logic signed [15:0] sample_out0, sample_out1, sample_out2, sample_out3;
  logic               rd_en;
  logic [12:0]        rd_addr;
  logic signed [15:0] rd_data = '0;
  logic               busy;
  logic [3:0]         voice_active;
  logic               overrun;

  int total = 0;
  int bad   = 0;
  int rd_cnt = 0;
  int last_addr = -1;

  sampler_voice_scheduler dut (
    .clk(clk), .rst(rst), .sample_strobe(sample_strobe),
    .sample_in0(sample_in0), .sample_in1(sample_in1),
    .sample_in2(sample_in2), .sample_in3(sample_in3),
    .sample_out0(sample_out0), .sample_out1(sample_out1),
    .sample_out2(sample_out2), .sample_out3(sample_out3),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .voice_active(voice_active), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // RAM model: RAM[i] = i, one-cycle registered read.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data   <= 16'(rd_addr);
      rd_cnt    <= rd_cnt + 1;
      last_addr <= int'(rd_addr);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; sample_strobe = 1'b0;
    sample_in0 = '0; sample_in1 = '0; sample_in2 = '0; sample_in3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One full sample period: strobe, then wait until the commit is visible.
  task automatic sweep();
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if ({sample_out0, sample_out1, sample_out2, sample_out3} !== 64'd0) begin bad++; $display("FAIL reset_outs: got %h expected 0", {sample_out0, sample_out1, sample_out2, sample_out3}); end
    total++; if (rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
    total++; if (rd_addr !== 13'd0) begin bad++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
    total++; if ({busy, overrun, voice_active} !== 6'd0) begin bad++; $display("FAIL reset_flags: got %b expected 000000", {busy, overrun, voice_active}); end
  endtask

  task automatic test_idle_zero();
    int c0;
    apply_reset();
    c0 = rd_cnt;
    repeat (3) sweep();
    total++; if ({sample_out0, sample_out1, sample_out2, sample_out3} !== 64'd0) begin bad++; $display("FAIL idle_outs: got %h expected 0", {sample_out0, sample_out1, sample_out2, sample_out3}); end
    total++; if (rd_cnt - c0 !== 0) begin bad++; $display("FAIL idle_rd_en: got %0d reads expected 0", rd_cnt - c0); end
    total++; if (voice_active !== 4'd0) begin bad++; $display("FAIL idle_active: got %b expected 0000", voice_active); end
  endtask

  task automatic test_voice0_seq();
    int exp_v [5] = '{0, 0, 1, 1, 2};
    apply_reset();
    sweep();
    sample_in0 = 16'sd4000;
    for (int k = 0; k < 5; k++) begin
      sweep();
      total++; if (sample_out0 !== 16'(exp_v[k])) begin bad++; $display("FAIL v0_out[%0d]: got %0d expected %0d", k, sample_out0, exp_v[k]); end
      total++; if (last_addr !== exp_v[k]) begin bad++; $display("FAIL v0_addr[%0d]: got %0d expected %0d", k, last_addr, exp_v[k]); end
      total++; if ({sample_out1, sample_out2, sample_out3} !== 48'd0) begin bad++; $display("FAIL v0_others[%0d]: got %h expected 0", k, {sample_out1, sample_out2, sample_out3}); end
      total++; if (voice_active !== 4'b0001) begin bad++; $display("FAIL v0_active[%0d]: got %b expected 0001", k, voice_active); end
    end
  endtask

  task automatic test_voice2_end();
    apply_reset();
    sweep();
    sample_in2 = 16'sd4000;
    for (int k = 2; k <= 3362; k++) begin
      sweep();
      if (k == 101) begin
        total++; if (sample_out2 !== 16'sd3409) begin bad++; $display("FAIL v2_mid: got %0d expected 3409", sample_out2); end
      end
      if (k == 3360 || k == 3361) begin
        total++; if (sample_out2 !== 16'sd5039) begin bad++; $display("FAIL v2_last[%0d]: got %0d expected 5039", k, sample_out2); end
      end
      if (k == 3360) begin
        total++; if (voice_active[2] !== 1'b1) begin bad++; $display("FAIL v2_active_late: got %b expected 1", voice_active[2]); end
      end
      if (k == 3362) begin
        total++; if (sample_out2 !== 16'sd0) begin bad++; $display("FAIL v2_end_out: got %0d expected 0", sample_out2); end
        total++; if (voice_active[2] !== 1'b0) begin bad++; $display("FAIL v2_end_active: got %b expected 0", voice_active[2]); end
      end
    end
  endtask

  task automatic test_trigger_hyst();
    int ins  [7] = '{3000, 4000, 3000, 4000, 4000, 1999, 4000};
    int outs [7] = '{0, 1680, 1680, 1680, 1681, 1681, 1680};
    apply_reset();
    sweep();
    for (int k = 0; k < 7; k++) begin
      sample_in1 = 16'(ins[k]);
      sweep();
      total++; if (sample_out1 !== 16'(outs[k])) begin bad++; $display("FAIL hyst_out[%0d]: got %0d expected %0d", k, sample_out1, outs[k]); end
    end
    total++; if (voice_active[1] !== 1'b1) begin bad++; $display("FAIL hyst_active: got %b expected 1", voice_active[1]); end
  endtask

  task automatic test_overrun();
    apply_reset();
    sweep();
    sample_in3 = 16'sd4000;
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovr_busy_start: got %b expected 1", busy); end
    repeat (3) @(negedge clk);
    sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set: got %b expected 1", overrun); end
    repeat (4) @(negedge clk);
    total++; if (busy !== 1'b1 || sample_out3 !== 16'sd0) begin bad++; $display("FAIL ovr_precommit: got busy=%b out3=%0d expected busy=1 out3=0", busy, sample_out3); end
    @(negedge clk);
    total++; if (busy !== 1'b0 || sample_out3 !== 16'sd5040) begin bad++; $display("FAIL ovr_commit: got busy=%b out3=%0d expected busy=0 out3=5040", busy, sample_out3); end
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ovr_next_accept: got %b expected 1", busy); end
    repeat (9) @(negedge clk);
    sweep();
    total++; if (sample_out3 !== 16'sd5041) begin bad++; $display("FAIL ovr_rdiv: got %0d expected 5041", sample_out3); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    sweep();
    sample_in1 = 16'sd4000;
    sweep();
    total++; if (sample_out1 !== 16'sd1680) begin bad++; $display("FAIL rmid_pre: got %0d expected 1680", sample_out1); end
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    total++; if (sample_out1 !== 16'sd0 || busy !== 1'b0 || voice_active !== 4'd0) begin bad++; $display("FAIL rmid_reset: got out1=%0d busy=%b act=%b expected 0 0 0000", sample_out1, busy, voice_active); end
    repeat (10) @(negedge clk);
    total++; if (sample_out1 !== 16'sd0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_nocommit: got out1=%0d busy=%b expected 0 0", sample_out1, busy); end
  endtask

  initial begin
    test_reset();
    test_idle_zero();
    test_voice0_seq();
    test_trigger_hyst();
    test_overrun();
    test_reset_mid();
    test_voice2_end();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sampler_voice_scheduler.md
# sampler_voice_scheduler

Four-voice playback controller that shares one single-port, registered-output sample RAM between four trigger channels. Each sample period it sweeps the voices in fixed order, issues one RAM read per active voice, and commits all four voice outputs together. It sits between the codec sample interface (inputs as triggers, outputs as audio) and a sample RAM holding four equal-length slots.

## Interface
- W, 16, sample and RAM data width (signed)
- FP_OFFSET, 2, mV-to-code shift; code = mV <<< FP_OFFSET
- SLOT_LEN, 1680, samples per voice slot; voice v occupies RAM addresses v*SLOT_LEN .. v*SLOT_LEN+SLOT_LEN-1
- ADDR_W, 13, RAM address width; must satisfy 2^ADDR_W >= 4*SLOT_LEN
- RATE_DIV, 2, sample strobes per playback position advance (>= 1)

Ports:
- clk, in, 1, the only clock. Reset is synchronous and active-high.
- rst, in, 1, synchronous active-high reset
- sample_strobe, in, 1, one-cycle pulse once per audio sample period
- sample_in0..3, in, W, signed trigger inputs for voices 0..3
- sample_out0..3, out, W, signed voice audio outputs
- rd_en, out, 1, RAM read request
- rd_addr, out, ADDR_W, RAM read address
- rd_data, in, W, RAM data, valid the cycle after rd_en
- busy, out, 1, sweep in progress
- voice_active, out, 4, bit v is high while voice v is playing
- overrun, out, 1, sticky: strobe arrived while busy

## Operation
- Trigger detection per voice, sampled only in cycles where sample_strobe is accepted. TRIGGER_LO = 500 mV <<< FP_OFFSET (2000). TRIGGER_HI = 1000 mV <<< FP_OFFSET (4000). Comparisons are signed.
  - An armed voice whose input is >= TRIGGER_HI fires and becomes disarmed.
  - A voice whose input is < TRIGGER_LO becomes armed.
  - Between the thresholds, the armed state holds.
- Firing sets the voice position pos_v = 0, which retriggers immediately even mid-playback, and marks the voice "fresh" for this sweep.
- A voice is active when pos_v < SLOT_LEN. Width of pos_v is clog2(SLOT_LEN+1).
- Rate divider rdiv counts accepted strobes, 0..RATE_DIV-1, then wraps to 0. Advance is enabled in a sweep when rdiv == 0 at the strobe.
- FSM states:
  - IDLE: on sample_strobe, evaluate triggers, set v = 0, go to ISSUE.
  - ISSUE: if voice v is active, rd_en = 1 and rd_addr = v*SLOT_LEN + pos_v; otherwise rd_en = 0. Go to CAPTURE.
  - CAPTURE: shadow_v = rd_data if voice v is active, else 0. If active, advance is enabled and the voice is not fresh, then pos_v += 1. If v == 3 go to COMMIT, else v += 1 and go to ISSUE.
  - COMMIT: sample_out0..3 <= shadow0..3 simultaneously; clear fresh flags. Go to IDLE.
- pos_v saturates at SLOT_LEN; an inactive voice outputs 0 V.
- rd_addr holds its last value when rd_en = 0.
- A sample_strobe in any state other than IDLE is dropped and sets overrun. overrun clears only on rst.
- The rdiv update and trigger evaluation happen only for accepted strobes.

## Timing
- Reset values:
  - sample_out0..3 = 0, rd_en = 0, rd_addr = 0, busy = 0, overrun = 0, voice_active = 0
  - all pos_v = SLOT_LEN, all voices disarmed, rdiv = 0, FSM state = IDLE
- rst asserted mid-sweep aborts the sweep next edge; no partial commit.
- A strobe seen at edge t gives the following schedule:
  - ISSUE v0 during cycle t+1.
  - CAPTURE v0 during cycle t+2.
  - Voice v ISSUE during cycle t+1+2v and CAPTURE during cycle t+2+2v.
  - COMMIT during cycle t+9.
  - Outputs change at edge t+10.
- busy is high during cycles t+1..t+9. The minimum strobe spacing without overrun is 10 cycles; a strobe at t+10 is accepted.
- voice_active is registered from pos_v and reflects the post-update positions one edge after each change.
- Read latency: rd_data is sampled during the CAPTURE cycle, exactly one cycle after rd_en.

## Test plan
- Reset, then send strobes with all inputs at 0 -> all outputs 0, rd_en never asserted, voice_active = 0.
- RAM[i] = i. Hold in0 = 0 for one strobe, then in0 = 4000 -> output 0 sequence on successive commits: 0, 0, 1, 1, 2, ... (RATE_DIV = 2, rdiv phase aligned). rd_addr = pos. Other outputs stay 0.
- Voice 2 triggered and playing to the end -> last committed value is RAM[2*1680+1679]. The next commit gives 0 and voice_active[2] = 0.
- in1 held at 3000 after arming -> no fire. Raise to 4000 -> fire. Drop to 3000 then raise to 4000 -> no retrigger. Drop to 1999 then raise to 4000 -> restart at pos 0.
- Strobes 5 cycles apart -> second strobe dropped, overrun = 1 and stays 1, and the sweep completes normally at t+10.
- rst pulsed at cycle t+4 of a sweep -> all outputs 0 the next edge, FSM returns to IDLE, and no commit occurs.
